// File: rtl/hazard_controller_pkg.sv
// Shared pipeline types for the hazard controller: stall status, FSM states,
// the bundled latch-control word and the load-use match helper.
package hazard_controller_pkg;

  typedef enum logic [2:0] {
    NO_STALL   = 3'd0,
    IFID_STALL = 3'd1,
    IDEX_STALL = 3'd2,
    FULL_STALL = 3'd3
  } pipe_stall_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } hzd_state_t;

  // Bit order is fixed so the datapath top can slice the word directly.
  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
  } pipe_ctrl_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam pipe_ctrl_t CTRL_ADVANCE = '{
    pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
    idex_flush: 1'b0, exmem_en: 1'b1, exmem_flush: 1'b0, memwb_en: 1'b1
  };

  localparam pipe_ctrl_t CTRL_FREEZE = '0;

  localparam pipe_ctrl_t CTRL_RESET = '{
    pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1, idex_en: 1'b0,
    idex_flush: 1'b1, exmem_en: 1'b0, exmem_flush: 1'b1, memwb_en: 1'b0
  };

  // $zero is hardwired, so a load targeting it can never create a hazard.
  function automatic logic load_use_hit(input logic       idex_rd,
                                        input logic [4:0] idex_rt,
                                        input logic [4:0] rs,
                                        input logic [4:0] rt);
    return idex_rd && (idex_rt != REG_ZERO) && ((idex_rt == rs) || (idex_rt == rt));
  endfunction

endpackage

// File: rtl/hazard_counters.sv
// Saturating stall-cycle and redirect-flush performance counters.
module hazard_counters #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_inc && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush_inc && (flush_count != '1))  flush_count  <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: per-cycle latch enables/flushes, PC hold,
// halt drain/lock FSM and performance counters.
module hazard_controller #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_DataRead,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_DataRead,
  input  logic             exmem_DataWrite,
  input  logic             ex_redirect,
  input  logic             memwb_Halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             exmem_flush,
  output logic             memwb_en,
  output logic [2:0]       stall,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  import hazard_controller_pkg::*;

  hzd_state_t  state, next_state;
  pipe_ctrl_t  ctrl;
  pipe_stall_t stall_s;
  logic        halt_s;
  logic        flush_take;
  logic        dmem_pending;

  assign dmem_pending = (exmem_DataRead || exmem_DataWrite) && !dhit;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    next_state = state;
    ctrl       = CTRL_ADVANCE;
    stall_s    = NO_STALL;
    halt_s     = 1'b0;
    flush_take = 1'b0;

    if (!nRST) begin
      ctrl = CTRL_RESET;
    end else if (state == HALTED) begin
      ctrl    = CTRL_FREEZE;
      stall_s = FULL_STALL;
      halt_s  = 1'b1;
    end else if (memwb_Halt) begin
      // MEM/WB already holds the halt; freeze everything behind it.
      next_state = HALTED;
      ctrl       = CTRL_FREEZE;
      stall_s    = FULL_STALL;
    end else if (dmem_pending) begin
      // ID/EX is frozen here, so a coincident redirect is re-presented later.
      next_state = DWAIT;
      ctrl       = CTRL_FREEZE;
      stall_s    = FULL_STALL;
    end else begin
      next_state = RUN;
      if (ex_redirect) begin
        ctrl.ifid_flush = 1'b1;
        ctrl.idex_flush = 1'b1;
        stall_s         = IDEX_STALL;
        flush_take      = 1'b1;
      end else if (load_use_hit(idex_DataRead, idex_rt, ifid_rs, ifid_rt)) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.idex_flush = 1'b1;
        stall_s         = IFID_STALL;
      end else if (!ihit) begin
        ctrl.pc_en      = 1'b0;
        ctrl.ifid_en    = 1'b0;
        ctrl.ifid_flush = 1'b1;
        stall_s         = IFID_STALL;
      end
    end
  end

  assign pc_en       = ctrl.pc_en;
  assign ifid_en     = ctrl.ifid_en;
  assign ifid_flush  = ctrl.ifid_flush;
  assign idex_en     = ctrl.idex_en;
  assign idex_flush  = ctrl.idex_flush;
  assign exmem_en    = ctrl.exmem_en;
  assign exmem_flush = ctrl.exmem_flush;
  assign memwb_en    = ctrl.memwb_en;
  assign stall       = stall_s;
  assign halt        = halt_s;

  hazard_counters #(.CNT_W(CNT_W)) u_counters (
    .CLK          (CLK),
    .nRST         (nRST),
    .stall_inc    ((stall_s != NO_STALL) && (state != HALTED)),
    .flush_inc    (flush_take),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller (counters narrowed to exercise saturation).
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  localparam int CNT_W = 4;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, idex_DataRead, exmem_DataRead, exmem_DataWrite, ex_redirect, memwb_Halt;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
  logic [2:0] stall;
  logic halt;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  always #5 CLK = ~CLK;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_DataRead(idex_DataRead), .idex_rt(idex_rt), .exmem_DataRead(exmem_DataRead),
    .exmem_DataWrite(exmem_DataWrite), .ex_redirect(ex_redirect), .memwb_Halt(memwb_Halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush), .memwb_en(memwb_en),
    .stall(stall), .halt(halt), .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  // Observation word: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, stall, halt}
  logic [11:0] obs;
  assign obs = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en, stall, halt};

  localparam logic [11:0] E_ADV    = {8'b1101_0101, NO_STALL,   1'b0};
  localparam logic [11:0] E_FROZEN = {8'b0000_0000, FULL_STALL, 1'b0};
  localparam logic [11:0] E_HALTED = {8'b0000_0000, FULL_STALL, 1'b1};
  localparam logic [11:0] E_LU     = {8'b0000_1101, IFID_STALL, 1'b0};
  localparam logic [11:0] E_REDIR  = {8'b1010_1101, IDEX_STALL, 1'b0};
  localparam logic [11:0] E_IMISS  = {8'b0011_0101, IFID_STALL, 1'b0};
  localparam logic [11:0] E_RESET  = {8'b0010_1010, 3'b000,     1'b0};
  localparam logic [11:0] M_ALL    = 12'hFFF;
  localparam logic [11:0] M_LU     = {8'b1110_1111, 3'b111, 1'b1};
  localparam logic [11:0] M_REDIR  = {8'b1010_1111, 3'b111, 1'b1};
  localparam logic [11:0] M_IMISS  = {8'b1011_1111, 3'b111, 1'b1};
  localparam logic [11:0] M_RESET  = {8'b1111_1111, 3'b000, 1'b1};

  typedef struct packed {
    logic       ihit, dhit;
    logic [4:0] rs, rt;
    logic       idex_rd;
    logic [4:0] idex_rt;
    logic       mem_rd, mem_wr, redirect, mhalt;
  } in_t;

  typedef struct {
    string       tag;
    logic [11:0] value;
    logic [11:0] mask;
  } sb_t;

  sb_t sb[$];
  sb_t exp_e;
  int  checks = 0;
  int  failures = 0;

  function automatic in_t mk(logic ih, logic dh, logic [4:0] rs, logic [4:0] rt, logic ld,
                             logic [4:0] lrt, logic mrd, logic mwr, logic red, logic mh);
    in_t v;
    v = '{ihit: ih, dhit: dh, rs: rs, rt: rt, idex_rd: ld, idex_rt: lrt,
          mem_rd: mrd, mem_wr: mwr, redirect: red, mhalt: mh};
    return v;
  endfunction

  localparam in_t IDLE = '{ihit: 1'b1, default: '0};

  task automatic drive(input in_t v);
    ihit = v.ihit; dhit = v.dhit; ifid_rs = v.rs; ifid_rt = v.rt;
    idex_DataRead = v.idex_rd; idex_rt = v.idex_rt;
    exmem_DataRead = v.mem_rd; exmem_DataWrite = v.mem_wr;
    ex_redirect = v.redirect; memwb_Halt = v.mhalt;
  endtask

  task automatic push(input string tag, input logic [11:0] value, input logic [11:0] mask);
    sb.push_back('{tag: tag, value: value, mask: mask});
  endtask

  task automatic apply_reset();
    drive(IDLE);
    nRST = 1'b0;
    @(posedge CLK); #1;
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    drive(IDLE);
    nRST = 1'b0;
    push("reset_hold", E_RESET, M_RESET);
    #2;
    exp_e = sb.pop_front();
    checks++;
    if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
      failures++; $display("FAIL %s: got %h want %h", exp_e.tag, obs & exp_e.mask, exp_e.value & exp_e.mask);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0));
      push("dwait_row", E_FROZEN, M_ALL);
      #1;
      exp_e = sb.pop_front();
      checks++;
      if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
        failures++; $display("FAIL %s[%0d]: got %h want %h", exp_e.tag, i, obs, exp_e.value);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (stall_cycles !== 4'd3) begin
      failures++; $display("FAIL dwait_stall_cycles: got %0d want 3", stall_cycles);
    end
    nRST = 1'b0;
    push("reset_async", E_RESET, M_RESET);
    #1;
    exp_e = sb.pop_front();
    checks++;
    if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask) || stall_cycles !== '0 || flush_count !== '0) begin
      failures++; $display("FAIL %s: got obs=%h stall_cycles=%0d flush_count=%0d want obs=%h counters=0",
                           exp_e.tag, obs & exp_e.mask, stall_cycles, flush_count, exp_e.value & exp_e.mask);
    end
    drive(IDLE);
    #2;
    nRST = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_load_use();
    in_t rows[5];
    logic [11:0] exps[5];
    apply_reset();
    rows[0] = mk(1'b1, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0); exps[0] = E_LU;
    rows[1] = IDLE;                                                           exps[1] = E_ADV;
    rows[2] = mk(1'b1, 1'b0, 5'd4, 5'd9, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0); exps[2] = E_LU;
    rows[3] = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0); exps[3] = E_ADV;
    rows[4] = mk(1'b0, 1'b0, 5'd1, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0); exps[4] = E_IMISS;
    for (int i = 0; i < 5; i++) begin
      drive(rows[i]);
      push("load_use", exps[i], (exps[i] == E_LU) ? M_LU : (exps[i] == E_IMISS) ? M_IMISS : M_ALL);
      #1;
      exp_e = sb.pop_front();
      checks++;
      if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
        failures++; $display("FAIL %s[%0d]: got %h want %h", exp_e.tag, i, obs & exp_e.mask, exp_e.value & exp_e.mask);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (stall_cycles !== 4'd3) begin
      failures++; $display("FAIL load_use_stall_cycles: got %0d want 3", stall_cycles);
    end
  endtask

  task automatic test_dmem_wait();
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      // Store waits 4 cycles, then a back-to-back load waits 1 cycle.
      logic hit;
      hit = (i == 4) || (i == 6);
      drive(mk(1'b1, hit, 5'd0, 5'd0, 1'b0, 5'd0, i > 4, i <= 4, 1'b0, 1'b0));
      push("dmem_wait", hit ? E_ADV : E_FROZEN, M_ALL);
      #1;
      exp_e = sb.pop_front();
      checks++;
      if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
        failures++; $display("FAIL %s[%0d]: got %h want %h", exp_e.tag, i, obs, exp_e.value);
      end
      @(posedge CLK); #1;
      if (i == 4) begin
        checks++;
        if (stall_cycles !== 4'd4) begin
          failures++; $display("FAIL dmem_stall_cycles: got %0d want 4", stall_cycles);
        end
      end
    end
  endtask

  task automatic test_redirect();
    in_t rows[5];
    logic [11:0] exps[5];
    apply_reset();
    rows[0] = mk(1'b1, 1'b0, 5'd8, 5'd3, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0); exps[0] = E_REDIR;
    rows[1] = mk(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); exps[1] = E_REDIR;
    rows[2] = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exps[2] = E_FROZEN;
    rows[3] = mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exps[3] = E_FROZEN;
    rows[4] = mk(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0); exps[4] = E_REDIR;
    for (int i = 0; i < 5; i++) begin
      drive(rows[i]);
      push("redirect", exps[i], (exps[i] == E_REDIR) ? M_REDIR : M_ALL);
      #1;
      exp_e = sb.pop_front();
      checks++;
      if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
        failures++; $display("FAIL %s[%0d]: got %h want %h", exp_e.tag, i, obs & exp_e.mask, exp_e.value & exp_e.mask);
      end
      @(posedge CLK); #1;
      if (i == 0) begin
        checks++;
        if (flush_count !== 4'd1) begin
          failures++; $display("FAIL redirect_flush_count: got %0d want 1", flush_count);
        end
      end
    end
    checks++;
    if (flush_count !== 4'd3 || stall_cycles !== 4'd5) begin
      failures++; $display("FAIL redirect_dmem_counters: got flush=%0d stall=%0d want flush=3 stall=5",
                           flush_count, stall_cycles);
    end
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 36; i++) begin
      logic red;
      red = (i >= 18);
      drive(mk(red, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, red, 1'b0));
      push("saturate", red ? E_REDIR : E_IMISS, red ? M_REDIR : M_IMISS);
      #1;
      exp_e = sb.pop_front();
      checks++;
      if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
        failures++; $display("FAIL %s[%0d]: got %h want %h", exp_e.tag, i, obs & exp_e.mask, exp_e.value & exp_e.mask);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (stall_cycles !== 4'hF || flush_count !== 4'hF) begin
      failures++; $display("FAIL saturate_counters: got stall=%0d flush=%0d want 15/15", stall_cycles, flush_count);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    for (int i = 0; i < 11; i++) begin
      if (i == 0) drive(mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1));
      else drive(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'd8, 5'd8, 1'b1, 5'd8,
                    1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0));
      push("halt", (i == 0) ? E_FROZEN : E_HALTED, M_ALL);
      #1;
      exp_e = sb.pop_front();
      checks++;
      if ((obs & exp_e.mask) !== (exp_e.value & exp_e.mask)) begin
        failures++; $display("FAIL %s[%0d]: got %h want %h", exp_e.tag, i, obs, exp_e.value);
      end
      @(posedge CLK); #1;
    end
    checks++;
    if (stall_cycles !== 4'd1 || flush_count !== 4'd0) begin
      failures++; $display("FAIL halt_counters: got stall=%0d flush=%0d want 1/0", stall_cycles, flush_count);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_dmem_wait();
    test_redirect();
    test_saturate();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
